csr_sys_ctrl: RTL and testbench
===============================

// Module: csr_sys_ctrl
// PURPOSE
// - Initiator side of the CSR-file interface: decodes SYSTEM-opcode instructions from EX and sequences CSR accesses.
// - Drives ecall/mret trap requests, redirects the front end to mtvec/mepc, stalls upstream and writes CSR results back to rd.
// - Sits between the EX stage and csr_file. It is the only block that drives csr_access, do_ecall, do_mret and instret_inc.
// PARAMETERS
// - XLEN        32  datapath width
// - PC_ALIGN    2   low PC bits forced to 0 on redirect (mtvec/mepc direct mode)
// PORTS
// - clk           in   1     clock
// - rst           in   1     asynchronous reset, active-high
// - ex_valid      in   1     EX holds a valid instruction
// - ex_ready      out  1     block can accept; high only in IDLE
// - ex_inst       in   32    instruction word
// - ex_pc         in   XLEN  instruction PC
// - ex_rs1_data   in   XLEN  forwarded rs1 value
// - ex_kill       in   1     older-instruction flush; drops an unaccepted request
// - csr_access    out  1     one-cycle CSR read/modify/write strobe
// - csr_funct3    out  3     latched funct3
// - csr_addr      out  12    latched inst[31:20]
// - csr_src       out  XLEN  rs1 value, or zero-extended uimm (inst[19:15]) when funct3[2]=1
// - csr_rdata     in   XLEN  combinational old CSR value
// - do_ecall      out  1     one-cycle trap-entry strobe
// - do_mret       out  1     one-cycle trap-return strobe
// - cur_pc        out  XLEN  latched PC of the SYSTEM instruction
// - mtvec_in      in   XLEN  current mtvec
// - mepc_in       in   XLEN  current mepc
// - instret_inc   out  1     one-cycle retire pulse
// - stall         out  1     freeze IF/ID/EX
// - flush         out  1     kill IF/ID contents
// - redirect_valid out 1     fetch redirect strobe
// - redirect_pc   out  XLEN  redirect target
// - rd_wen        out  1     register-file write enable
// - rd_addr       out  5     destination register
// - rd_wdata      out  XLEN  old CSR value
// BEHAVIOUR
// - Reset values: all outputs 0 except ex_ready=1. State=IDLE. All latches cleared.
// - Accept: in IDLE, when ex_valid & is_system & ~ex_kill, latch inst, pc and rs1_data. Then:
//   - CSR op (funct3 != 000 and != 100): go to ACCESS.
//   - ECALL (0x00000073): go to TRAP.
//   - MRET (0x30200073): go to RET.
//   - Other funct3=000 encodings (ebreak, wfi) and funct3=100: go to WB as a NOP, with rd_wen=0.
// - stall = (state != IDLE) | (ex_valid & is_system & ~ex_kill).
// - ACCESS (1 cycle):
//   - Drive csr_access=1 with funct3, addr and src.
//   - Capture csr_rdata into old_q on the same edge that csr_file commits the write.
//   - Next state: WB.
// - WB (1 cycle):
//   - rd_wen = is_csr & (rd != 0).
//   - rd_wdata = old_q.
//   - instret_inc = 1.
//   - Next state: IDLE.
// - TRAP (1 cycle):
//   - Drive do_ecall=1 and cur_pc=latched pc.
//   - redirect_valid=1, flush=1.
//   - redirect_pc = mtvec_in with PC_ALIGN low bits cleared.
//   - Next state: IDLE. No instret_inc, since ecall does not retire.
// - RET (1 cycle):
//   - Drive do_mret=1, redirect_valid=1, flush=1.
//   - redirect_pc = mepc_in with PC_ALIGN low bits cleared.
//   - instret_inc = 1.
//   - Next state: IDLE.
// - Latency: CSR op is accept T, ACCESS T+1, WB T+2, new accept T+3. Trap and mret redirect at T+1.
// - csr_access, do_ecall and do_mret are mutually exclusive and never high for two consecutive cycles.
// - ex_kill in the same cycle as ex_valid in IDLE: request dropped, no state change.
// - ex_kill after accept: ignored, because the operation is committed.
// - Reset mid-operation (any state): immediately return to IDLE. Strobes drop asynchronously; no partial CSR write is issued afterwards.
// - csr_src is passed through unmodified. Write suppression for rs/rc with zero source is owned by csr_file.
// STRUCTURE
// - define.v owns these shared constants:
//   - OPC_SYSTEM 7'b1110011
//   - CSR funct3 codes
//   - ECALL and MRET encodings
//   - state encodings IDLE, ACCESS, WB, TRAP, RET
// - One sub-module, csr_sys_decode: combinational; outputs is_system, is_csr, is_ecall, is_mret, is_nop, rd and uimm.
// - The top level holds the FSM, the latches and the output muxing.
// TESTING
// - csrrw x5,mtvec,x6 with x6=0x80000100, old mtvec=0:
//   - csr_access pulses at T+1 with csr_src=0x80000100.
//   - At T+2: rd_wen=1, rd_addr=5, rd_wdata=0, instret_inc=1.
// - csrrsi x0,mstatus,8:
//   - csr_src=0x8 at T+1.
//   - At T+2: rd_wen=0 and instret_inc=1.
// - ecall at pc=0x100 with mtvec=0x203:
//   - At T+1: do_ecall=1, cur_pc=0x100, redirect_pc=0x200, flush=1.
//   - No instret_inc.
// - mret with mepc=0x104:
//   - At T+1: do_mret=1, redirect_pc=0x104, instret_inc=1.
// - ex_valid and ex_kill high together in IDLE:
//   - No strobes and stall=0.
//   - Next SYSTEM instruction is accepted normally.
// - rst asserted during ACCESS:
//   - csr_access=0 immediately and state=IDLE.
//   - After release, a csrrw completes with the correct 3-cycle timing.

Source files
------------

// File: rtl/csr_sys_ctrl_pkg.sv
// rtl/csr_sys_ctrl_pkg.sv - shared SYSTEM-opcode constants and FSM state encodings
package csr_sys_ctrl_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0]  F3_PRIV    = 3'b000;
    localparam logic [2:0]  F3_CSRRW   = 3'b001;
    localparam logic [2:0]  F3_CSRRS   = 3'b010;
    localparam logic [2:0]  F3_CSRRC   = 3'b011;
    localparam logic [2:0]  F3_RSVD    = 3'b100;
    localparam logic [2:0]  F3_CSRRWI  = 3'b101;
    localparam logic [2:0]  F3_CSRRSI  = 3'b110;
    localparam logic [2:0]  F3_CSRRCI  = 3'b111;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_ACCESS  = 3'd1;
    localparam logic [2:0]  ST_WB      = 3'd2;
    localparam logic [2:0]  ST_TRAP    = 3'd3;
    localparam logic [2:0]  ST_RET     = 3'd4;

    function automatic logic is_csr_funct3(input logic [2:0] f3);
        return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC) ||
               (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
    endfunction

endpackage

// File: rtl/csr_sys_decode.sv
// rtl/csr_sys_decode.sv - combinational classifier for SYSTEM-opcode instructions
module csr_sys_decode
    import csr_sys_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_system,
    output logic        is_csr,
    output logic        is_ecall,
    output logic        is_mret,
    output logic        is_nop,
    output logic [4:0]  rd,
    output logic [4:0]  uimm
);

    logic [2:0] funct3;

    assign funct3    = inst[14:12];
    assign is_system = (inst[6:0] == OPC_SYSTEM);
    assign is_csr    = is_system & is_csr_funct3(funct3);
    assign is_ecall  = (inst == INST_ECALL);
    assign is_mret   = (inst == INST_MRET);
    // ebreak, wfi and the reserved funct3 retire without side effects
    assign is_nop    = is_system & ~is_csr & ~is_ecall & ~is_mret &
                       ((funct3 == F3_PRIV) | (funct3 == F3_RSVD));
    assign rd        = inst[11:7];
    assign uimm      = inst[19:15];

endmodule

// File: rtl/csr_sys_ctrl.sv
// rtl/csr_sys_ctrl.sv - SYSTEM instruction sequencer driving CSR accesses, traps and redirects
module csr_sys_ctrl
    import csr_sys_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic            ex_kill,
    output logic            csr_access,
    output logic [2:0]      csr_funct3,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_src,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            do_ecall,
    output logic            do_mret,
    output logic [XLEN-1:0] cur_pc,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            instret_inc,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << PC_ALIGN) - XLEN'(1));

    logic            dec_system;
    logic            dec_csr;
    logic            dec_ecall;
    logic            dec_mret;
    logic            dec_nop;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_uimm;

    logic [2:0]      state_q;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;
    logic [4:0]      rd_q;
    logic            is_csr_q;
    logic            request;
    logic            accept;

    csr_sys_decode u_decode (
        .inst      (ex_inst),
        .is_system (dec_system),
        .is_csr    (dec_csr),
        .is_ecall  (dec_ecall),
        .is_mret   (dec_mret),
        .is_nop    (dec_nop),
        .rd        (dec_rd),
        .uimm      (dec_uimm)
    );

    assign request = ex_valid & dec_system & ~ex_kill;
    assign accept  = request & (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            addr_q   <= '0;
            src_q    <= '0;
            pc_q     <= '0;
            old_q    <= '0;
            rd_q     <= '0;
            is_csr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        funct3_q <= ex_inst[14:12];
                        addr_q   <= ex_inst[31:20];
                        src_q    <= ex_inst[14] ? {{(XLEN-5){1'b0}}, dec_uimm} : ex_rs1_data;
                        pc_q     <= ex_pc;
                        rd_q     <= dec_rd;
                        is_csr_q <= dec_csr;
                        old_q    <= '0;
                        if (dec_csr)       state_q <= ST_ACCESS;
                        else if (dec_ecall) state_q <= ST_TRAP;
                        else if (dec_mret)  state_q <= ST_RET;
                        else if (dec_nop)   state_q <= ST_WB;
                        else                state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // csr_rdata still shows the pre-write value on the commit edge
                    old_q   <= csr_rdata;
                    state_q <= ST_WB;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset kills them at once
    assign ex_ready       = (state_q == ST_IDLE);
    assign stall          = (state_q != ST_IDLE) | request;
    assign csr_access     = (state_q == ST_ACCESS);
    assign csr_funct3     = funct3_q;
    assign csr_addr       = addr_q;
    assign csr_src        = src_q;
    assign do_ecall       = (state_q == ST_TRAP);
    assign do_mret        = (state_q == ST_RET);
    assign cur_pc         = pc_q;
    assign instret_inc    = (state_q == ST_WB) | (state_q == ST_RET);
    assign flush          = (state_q == ST_TRAP) | (state_q == ST_RET);
    assign redirect_valid = flush;
    assign rd_wen         = (state_q == ST_WB) & is_csr_q & (rd_q != 5'd0);
    assign rd_addr        = rd_q;
    assign rd_wdata       = old_q;

    always_comb begin
        redirect_pc = '0;
        if (state_q == ST_TRAP)     redirect_pc = mtvec_in & ALIGN_MASK;
        else if (state_q == ST_RET) redirect_pc = mepc_in & ALIGN_MASK;
    end

endmodule

// File: tb/tb_csr_sys_ctrl.sv
// tb/tb_csr_sys_ctrl.sv - self-checking bench for csr_sys_ctrl with a per-cycle expectation queue
module tb_csr_sys_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic        ex_kill;
    logic        csr_access;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic [31:0] csr_rdata;
    logic        do_ecall;
    logic        do_mret;
    logic [31:0] cur_pc;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        instret_inc;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    csr_sys_ctrl #(.XLEN(32), .PC_ALIGN(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_kill(ex_kill),
        .csr_access(csr_access), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
        .csr_src(csr_src), .csr_rdata(csr_rdata), .do_ecall(do_ecall), .do_mret(do_mret),
        .cur_pc(cur_pc), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .instret_inc(instret_inc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        acc, ecall, mret, inc, flsh, redir, wen, ready, stl;
        logic [31:0] rpc, wdata, src, pc;
        logic [4:0]  rd;
        logic [11:0] addr;
        logic [2:0]  f3;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] csr_mem [0:4095];
    logic [31:0] seen_src, seen_wdata, seen_rpc, seen_cur_pc;
    int          inc_cnt = 0;

    always_comb csr_rdata = csr_mem[csr_addr];

    // Stand-in csr_file: commits the read/modify/write on the access edge
    always @(posedge clk) begin
        if (!rst && csr_access) begin
            case (csr_funct3[1:0])
                2'b01:   csr_mem[csr_addr] <= csr_src;
                2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_src;
                2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_src;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.acc = 0; e.ecall = 0; e.mret = 0; e.inc = 0; e.flsh = 0; e.redir = 0;
        e.wen = 0; e.ready = 1; e.stl = 0;
        e.rpc = 0; e.wdata = 0; e.src = 0; e.pc = 0; e.rd = 0; e.addr = 0; e.f3 = 0;
        return e;
    endfunction

    function automatic exp_t busy_exp();
        exp_t e = idle_exp();
        e.ready = 0;
        e.stl   = 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            e = (expq.size() != 0) ? expq.pop_front() : idle_exp();
            chk("ex_ready", ex_ready, e.ready);
            chk("stall", stall, e.stl);
            chk("csr_access", csr_access, e.acc);
            chk("do_ecall", do_ecall, e.ecall);
            chk("do_mret", do_mret, e.mret);
            chk("instret_inc", instret_inc, e.inc);
            chk("flush", flush, e.flsh);
            chk("redirect_valid", redirect_valid, e.redir);
            chk("rd_wen", rd_wen, e.wen);
            if (e.acc) begin
                chk("csr_src", csr_src, e.src);
                chk("csr_addr", csr_addr, e.addr);
                chk("csr_funct3", csr_funct3, e.f3);
            end
            if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
            if (e.ecall) chk("cur_pc", cur_pc, e.pc);
            if (e.wen) begin
                chk("rd_addr", rd_addr, e.rd);
                chk("rd_wdata", rd_wdata, e.wdata);
            end
            if (csr_access) seen_src = csr_src;
            if (rd_wen) seen_wdata = rd_wdata;
            if (redirect_valid) seen_rpc = redirect_pc;
            if (do_ecall) seen_cur_pc = cur_pc;
            if (instret_inc) inc_cnt++;
        end
    end

    // Caller sits at a rising edge; the request is presented for exactly one cycle
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic kill);
        exp_t e;
        logic [2:0] f3;
        logic sys;
        int n;
        f3  = inst[14:12];
        sys = (inst[6:0] == 7'h73);
        #1;
        ex_valid = 1; ex_inst = inst; ex_pc = pc; ex_rs1_data = rs1; ex_kill = kill;
        e = idle_exp();
        e.stl = sys & ~kill;
        expq.push_back(e);
        if (sys && !kill) begin
            if (f3 != 3'd0 && f3 != 3'd4) begin
                e = busy_exp();
                e.acc = 1; e.addr = inst[31:20]; e.f3 = f3;
                e.src = f3[2] ? {27'd0, inst[19:15]} : rs1;
                expq.push_back(e);
                e = busy_exp();
                e.inc = 1; e.rd = inst[11:7]; e.wen = (inst[11:7] != 5'd0);
                e.wdata = csr_mem[inst[31:20]];
                expq.push_back(e);
            end else if (inst == 32'h0000_0073) begin
                e = busy_exp();
                e.ecall = 1; e.redir = 1; e.flsh = 1; e.pc = pc;
                e.rpc = {mtvec_in[31:2], 2'b00};
                expq.push_back(e);
            end else if (inst == 32'h3020_0073) begin
                e = busy_exp();
                e.mret = 1; e.redir = 1; e.flsh = 1; e.inc = 1;
                e.rpc = {mepc_in[31:2], 2'b00};
                expq.push_back(e);
            end else begin
                e = busy_exp();
                e.inc = 1;
                expq.push_back(e);
            end
        end
        @(posedge clk); #1;
        ex_valid = 0; ex_kill = 0;
        n = 0;
        while (expq.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            chk("drain_timeout", expq.size(), 0);
            expq.delete();
        end
    endtask

    initial begin
        int inc_before;
        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
        csr_mem[12'h340] = 32'h0000_0F0F;
        rst = 1; ex_valid = 0; ex_inst = 0; ex_pc = 0; ex_rs1_data = 0; ex_kill = 0;
        mtvec_in = 32'h0000_0203; mepc_in = 32'h0000_0104;
        #12;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_strobes", {csr_access, do_ecall, do_mret, instret_inc, flush, redirect_valid, rd_wen}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_cur_pc", cur_pc, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk);

        // csrrw x5, mtvec, x6 then back-to-back csrrsi x0, mstatus, 8
        issue(32'h3053_12F3, 32'h0000_0040, 32'h8000_0100, 1'b0);
        chk("lit_csrrw_src", seen_src, 32'h8000_0100);
        chk("lit_csrrw_old", seen_wdata, 32'h0000_0000);
        chk("lit_mtvec_written", csr_mem[12'h305], 32'h8000_0100);
        issue(32'h3004_6073, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
        chk("lit_csrrsi_src", seen_src, 32'h0000_0008);

        @(posedge clk);
        inc_before = inc_cnt;
        issue(32'h0000_0073, 32'h0000_0100, 32'd0, 1'b0);
        chk("lit_ecall_rpc", seen_rpc, 32'h0000_0200);
        chk("lit_ecall_pc", seen_cur_pc, 32'h0000_0100);
        chk("lit_ecall_no_retire", inc_cnt - inc_before, 0);
        issue(32'h3020_0073, 32'h0000_0200, 32'd0, 1'b0);
        chk("lit_mret_rpc", seen_rpc, 32'h0000_0104);
        chk("lit_mret_retire", inc_cnt - inc_before, 1);

        // killed request, then csrrs x7, mtvec, x0 accepted normally
        @(posedge clk);
        issue(32'h3053_12F3, 32'h0000_0300, 32'h1111_1111, 1'b1);
        issue(32'h3050_23F3, 32'h0000_0304, 32'd0, 1'b0);
        chk("lit_csrrs_old", seen_wdata, 32'h8000_0100);
        issue(32'h0010_0093, 32'h0000_0308, 32'd0, 1'b0);
        issue(32'h0010_0073, 32'h0000_030C, 32'd0, 1'b0);

        // reset while in ACCESS: strobe must drop without waiting for a clock
        @(posedge clk); #1;
        ex_valid = 1; ex_inst = 32'h3403_12F3; ex_pc = 32'h400; ex_rs1_data = 32'h1234_5678;
        begin
            exp_t e = idle_exp();
            e.stl = 1;
            expq.push_back(e);
        end
        @(posedge clk); #1;
        ex_valid = 0;
        chk("lit_access_before_rst", csr_access, 1);
        rst = 1;
        expq.delete();
        #1;
        chk("rst_mid_access", csr_access, 0);
        chk("rst_mid_ready", ex_ready, 1);
        chk("rst_mid_stall", stall, 0);
        @(posedge clk); #1 rst = 0;
        chk("lit_no_partial_write", csr_mem[12'h340], 32'h0000_0F0F);
        @(posedge clk);
        issue(32'h3401_30F3, 32'h0000_0410, 32'h0000_000F, 1'b0);
        chk("lit_csrrc_old", seen_wdata, 32'h0000_0F0F);
        chk("lit_csrrc_new", csr_mem[12'h340], 32'h0000_0F00);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
